goertzel_tone_gen: RTL and testbench

Recursive-resonator tone synthesizer. It is the transmit-side counterpart of the Goertzel detector and uses the same recurrence, y[n] = alpha*y[n-1] - y[n-2] with alpha = 2cos(w). One start command produces a burst of NS signed sinusoid samples on a valid/ready stream. The block drives detector stimulus and in-band test tones.

---
 rtl/goertzel_tone_gen.sv | 153 +++++++++++++++
 tb/tb_goertzel_tone_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_tone_gen.sv
// Recursive-resonator tone burst generator: y[n] = alpha*y[n-1] - y[n-2], NS samples per start.
// Latency: first sample valid 1 cycle after start; 1 sample/cycle while ready_i is high, data holds otherwise.
module goertzel_tone_gen #(
  parameter int NS   = 1000,
  parameter int FRAC = 30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] alpha_i,
  input  logic [31:0] init1_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        sat_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NS - 1);
  localparam logic signed [63:0] RND = 64'sd1 <<< (FRAC - 1);
  localparam logic signed [63:0] POS_MAX = 64'sd2147483647;
  localparam logic signed [63:0] NEG_MIN = -64'sd2147483648;

  state_t      state;
  logic [15:0] idx;
  logic [31:0] y1;
  logic [31:0] y2;
  logic [31:0] alpha_r;
  logic [31:0] init1_r;

  logic signed [63:0] a64;
  logic signed [63:0] y1_64;
  logic signed [63:0] y2_64;
  logic signed [63:0] prod;
  logic signed [63:0] rnd;
  logic signed [63:0] sum;
  logic               ovf_hi;
  logic               ovf_lo;
  logic [31:0]        rec_y;
  logic [31:0]        next_y;
  logic               next_sat;
  logic [15:0]        idx_nx;
  logic               hs;

  // Wide difference is range-checked at full width; identical to the 34-bit result for any 32-bit operands.
  always_comb begin
    a64    = {{32{alpha_r[31]}}, alpha_r};
    y1_64  = {{32{y1[31]}}, y1};
    y2_64  = {{32{y2[31]}}, y2};
    prod   = a64 * y1_64;
    rnd    = (prod + RND) >>> FRAC;
    sum    = rnd - y2_64;
    ovf_hi = (sum > POS_MAX);
    ovf_lo = (sum < NEG_MIN);
    if (ovf_hi)      rec_y = 32'h7fff_ffff;
    else if (ovf_lo) rec_y = 32'h8000_0000;
    else             rec_y = sum[31:0];
  end

  // y[1] is not produced by the recurrence; it comes straight from the latched init value.
  always_comb begin
    if (idx == 16'd0) begin
      next_y   = init1_r;
      next_sat = 1'b0;
    end else begin
      next_y   = rec_y;
      next_sat = ovf_hi | ovf_lo;
    end
    idx_nx = idx + 16'd1;
    hs     = valid_o & ready_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= 16'd0;
      y1      <= 32'd0;
      y2      <= 32'd0;
      alpha_r <= 32'd0;
      init1_r <= 32'd0;
      valid_o <= 1'b0;
      data_o  <= 32'd0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sat_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i && !abort_i) begin
            alpha_r <= alpha_i;
            init1_r <= init1_i;
            idx     <= 16'd0;
            y1      <= 32'd0;
            y2      <= 32'd0;
            data_o  <= 32'd0;
            valid_o <= 1'b1;
            last_o  <= (LAST_IDX == 16'd0);
            sat_o   <= 1'b0;
            busy_o  <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (abort_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            state   <= IDLE;
          end else if (hs) begin
            if (last_o) begin
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              done_o  <= 1'b1;
              state   <= DONE;
            end else begin
              idx    <= idx_nx;
              y2     <= y1;
              y1     <= next_y;
              data_o <= next_y;
              last_o <= (idx_nx == LAST_IDX);
              if (next_sat) sat_o <= 1'b1;
            end
          end
        end

        DONE: begin
          // Abort here lands in the same place; only the done pulse differs, and it ends either way.
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Directed bench for goertzel_tone_gen: three instances (NS=8, 4, 1), hand-computed sample tables.
module tb_goertzel_tone_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] alpha = 32'd0, init1 = 32'd0;

  logic        v8, l8, b8, dn8, s8;
  logic [31:0] d8;
  logic        v4, l4, b4, dn4, s4;
  logic [31:0] d4;
  logic        v1, l1, b1, dn1, s1;
  logic [31:0] d1;

  goertzel_tone_gen #(.NS(8), .FRAC(30)) u8 (
    .clk(clk), .rstn(rstn), .start_i(start8), .abort_i(abort), .alpha_i(alpha), .init1_i(init1),
    .ready_i(ready), .valid_o(v8), .data_o(d8), .last_o(l8), .busy_o(b8), .done_o(dn8), .sat_o(s8));
  goertzel_tone_gen #(.NS(4), .FRAC(30)) u4 (
    .clk(clk), .rstn(rstn), .start_i(start4), .abort_i(abort), .alpha_i(alpha), .init1_i(init1),
    .ready_i(ready), .valid_o(v4), .data_o(d4), .last_o(l4), .busy_o(b4), .done_o(dn4), .sat_o(s4));
  goertzel_tone_gen #(.NS(1), .FRAC(30)) u1 (
    .clk(clk), .rstn(rstn), .start_i(start1), .abort_i(abort), .alpha_i(alpha), .init1_i(init1),
    .ready_i(ready), .valid_o(v1), .data_o(d1), .last_o(l1), .busy_o(b1), .done_o(dn1), .sat_o(s1));

  int          sel = 8;
  logic        vld, lst, bsy, dne, sat;
  logic [31:0] dat;

  always_comb begin
    vld = v8; lst = l8; bsy = b8; dne = dn8; sat = s8; dat = d8;
    case (sel)
      4: begin vld = v4; lst = l4; bsy = b4; dne = dn4; sat = s4; dat = d4; end
      1: begin vld = v1; lst = l1; bsy = b1; dne = dn1; sat = s1; dat = d1; end
      default: ;
    endcase
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    start8 = (s == 8) ? v : 1'b0;
    start4 = (s == 4) ? v : 1'b0;
    start1 = (s == 1) ? v : 1'b0;
  endtask

  logic [31:0] ev [8];
  int          sat_from;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Starts a burst on instance s and consumes it; bp selects the 1,0,0,1,0,1 ready pattern.
  task automatic burst(input string name, input int s, input int ns, input logic [31:0] a,
                       input logic [31:0] i1, input bit bp);
    int n;
    int cyc;
    bit hold;
    logic [31:0] pdat;
    sel = s;
    alpha = a;
    init1 = i1;
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    alpha = 32'hdead_beef;
    init1 = 32'h1234_5678;
    n = 0; cyc = 0; hold = 1'b0; pdat = 32'd0;
    while (n < ns && cyc < 200) begin
      set_start(s, 1'b0);
      if (hold) chk($sformatf("%s hold_data", name), dat, pdat);
      ready = bp ? pat[cyc % 6] : 1'b1;
      if (bp && cyc == 3) set_start(s, 1'b1);
      chk($sformatf("%s valid c%0d", name, cyc), {31'd0, vld}, 32'd1);
      if (ready) begin
        chk($sformatf("%s y[%0d]", name, n), dat, ev[n]);
        chk($sformatf("%s last[%0d]", name, n), {31'd0, lst}, {31'd0, n == ns - 1});
        chk($sformatf("%s sat[%0d]", name, n), {31'd0, sat},
            {31'd0, (sat_from >= 0) && (n >= sat_from)});
        n++;
      end
      hold = !ready;
      pdat = dat;
      @(negedge clk);
      cyc++;
    end
    set_start(s, 1'b0);
    if (cyc >= 200) chk($sformatf("%s timeout", name), 32'd0, 32'd1);
    ready = 1'b1;
    chk($sformatf("%s done_pulse", name), {31'd0, dne}, 32'd1);
    chk($sformatf("%s valid_off", name), {31'd0, vld}, 32'd0);
    chk($sformatf("%s busy_done", name), {31'd0, bsy}, 32'd1);
    chk($sformatf("%s sat_end", name), {31'd0, sat}, {31'd0, sat_from >= 0});
    if (bp) set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    chk($sformatf("%s done_clear", name), {31'd0, dne}, 32'd0);
    chk($sformatf("%s busy_idle", name), {31'd0, bsy}, 32'd0);
    chk($sformatf("%s no_restart", name), {31'd0, vld}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst valid", {31'd0, v8}, 32'd0);
    chk("rst data", d8, 32'd0);
    chk("rst last", {31'd0, l8}, 32'd0);
    chk("rst busy", {31'd0, b8}, 32'd0);
    chk("rst done", {31'd0, dn8}, 32'd0);
    chk("rst sat", {31'd0, s8}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    sat_from = -1;
    ev = '{32'sd0, 32'sd1000, 32'sd0, -32'sd1000, 32'sd0, 32'sd1000, 32'sd0, -32'sd1000};
    burst("a0", 8, 8, 32'd0, 32'd1000, 1'b0);

    ev = '{32'sd0, 32'sd1000, 32'sd1000, 32'sd0, -32'sd1000, -32'sd1000, 32'sd0, 32'sd1000};
    burst("pi3", 8, 8, 32'h4000_0000, 32'd1000, 1'b0);

    sat_from = 3;
    ev = '{32'sd0, 32'h4000_0000, 32'h8000_0000, 32'h7fff_ffff, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    burst("sat", 4, 4, 32'h8000_0000, 32'h4000_0000, 1'b0);

    sat_from = -1;
    ev = '{32'sd0, 32'sd3, 32'sd2, -32'sd2, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    burst("rnd", 4, 4, 32'h2000_0000, 32'd3, 1'b0);

    ev = '{32'sd0, 32'sd1000, 32'sd1000, 32'sd0, -32'sd1000, -32'sd1000, 32'sd0, 32'sd1000};
    burst("bp", 8, 8, 32'h4000_0000, 32'd1000, 1'b1);

    ev = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    burst("ns1", 1, 1, 32'h4000_0000, 32'd77, 1'b0);

    // abort on the third sample, racing a handshake
    sel = 8;
    alpha = 32'd0; init1 = 32'd1000; ready = 1'b1;
    set_start(8, 1'b1);
    @(negedge clk);
    set_start(8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort y[2]", dat, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valid", {31'd0, vld}, 32'd0);
    chk("abort last", {31'd0, lst}, 32'd0);
    chk("abort busy", {31'd0, bsy}, 32'd0);
    chk("abort done", {31'd0, dne}, 32'd0);
    @(negedge clk);
    chk("abort done2", {31'd0, dne}, 32'd0);

    // abort together with start in IDLE cancels the start
    abort = 1'b1;
    set_start(8, 1'b1);
    @(negedge clk);
    abort = 1'b0;
    set_start(8, 1'b0);
    chk("abort+start busy", {31'd0, bsy}, 32'd0);
    chk("abort+start valid", {31'd0, vld}, 32'd0);

    ev = '{32'sd0, 32'sd1000, 32'sd0, -32'sd1000, 32'sd0, 32'sd1000, 32'sd0, -32'sd1000};
    burst("post_abort", 8, 8, 32'd0, 32'd1000, 1'b0);

    // asynchronous reset in mid-burst, sampled between clock edges
    sel = 8;
    alpha = 32'h4000_0000; init1 = 32'd1000; ready = 1'b1;
    set_start(8, 1'b1);
    @(negedge clk);
    set_start(8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst valid", {31'd0, v8}, 32'd0);
    chk("arst data", d8, 32'd0);
    chk("arst busy", {31'd0, b8}, 32'd0);
    chk("arst last", {31'd0, l8}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst stays idle", {31'd0, v8}, 32'd0);

    ev = '{32'sd0, 32'sd1000, 32'sd1000, 32'sd0, -32'sd1000, -32'sd1000, 32'sd0, 32'sd1000};
    burst("post_rst", 8, 8, 32'h4000_0000, 32'd1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
